// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared load/store unit types and decode helpers.
package lib_cpu;

   // Access size/sign encoding; stores reuse LB/LH/LW for SB/SH/SW.
   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } lsu_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } lsu_state_t;

   // Halfwords need an even address, words need a 4-byte aligned address.
   function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] a);
      case (op[1:0])
         2'b01:   return a[0];
         2'b10:   return a != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // 011/110/111 are never legal; unsigned variants (1xx) make no sense for stores.
   function automatic logic lsu_illegal(input logic [2:0] op, input logic we);
      return (op[1:0] == 2'b11) || (op[2] && (we || op[1]));
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane selection: load extension and store merge.
module lsu_lane_align
   import lib_cpu::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [31:0] sdata
);

   logic [7:0]  b;
   logic [15:0] h;

   assign b = word[{lane, 3'b000} +: 8];
   assign h = lane[1] ? word[31:16] : word[15:0];

   // Extract the addressed lane and sign/zero extend it.
   always_comb begin
      case (op)
         LB:      ldata = {{24{b[7]}}, b};
         LH:      ldata = {{16{h[15]}}, h};
         LBU:     ldata = {24'h0, b};
         LHU:     ldata = {16'h0, h};
         default: ldata = word;
      endcase
   end

   // Replace the addressed lane of the old word; full-word stores take wdata whole.
   always_comb begin
      sdata = word;
      case (op[1:0])
         2'b00: sdata[{lane, 3'b000} +: 8] = wdata[7:0];
         2'b01: begin
            if (lane[1]) sdata[31:16] = wdata[15:0];
            else         sdata[15:0]  = wdata[15:0];
         end
         default: sdata = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the single-port data memory file.
module lsu_mem_ctrl
   import lib_cpu::*;
#(
   parameter int          WORDS_LOG2 = 6,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  mem_w_en,
   output logic [31:0]           mem_w_data,
   output logic [WORDS_LOG2-1:0] mem_addr,
   input  logic [31:0]           mem_r_data
);

   localparam logic [31:0] SPAN = 32'd4 << WORDS_LOG2;

   lsu_state_t              state, state_nx;
   logic [2:0]              op_q;
   logic                    we_q;
   logic [WORDS_LOG2+1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic [31:0]             rbuf;
   logic                    req_err;
   logic [31:0]             align_word;
   logic [31:0]             ldata;
   logic [31:0]             sdata;

   // Errors are judged on the incoming request so the accept edge can route straight to S_RESP.
   assign req_err = lsu_illegal(req_op, req_we)
                 || lsu_misaligned(req_op, req_addr[1:0])
                 || ((req_addr - BASE_ADDR) >= SPAN);

   // The merge in S_WRITE works on the buffered old word; loads extract straight from memory.
   assign align_word = (state == S_WRITE) ? rbuf : mem_r_data;

   lsu_lane_align u_align (
      .op    (op_q),
      .lane  (addr_q[1:0]),
      .word  (align_word),
      .wdata (wdata_q),
      .ldata (ldata),
      .sdata (sdata)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state: SW skips the read, sub-word stores read-modify-write.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_err)                     state_nx = S_RESP;
               else if (req_we && req_op == LW) state_nx = S_WRITE;
               else                             state_nx = S_READ;
            end
         end
         S_READ:  state_nx = we_q ? S_WRITE : S_RESP;
         S_WRITE: state_nx = S_RESP;
         S_RESP:  if (resp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs decoded from state so reset kills the write strobe and response at once.
   always_comb begin
      req_ready  = (state == S_IDLE);
      resp_valid = (state == S_RESP);
      mem_w_en   = (state == S_WRITE);
      mem_addr   = addr_q[WORDS_LOG2+1:2];
      mem_w_data = sdata;
   end

   // Request latch, read buffer and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q       <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rbuf       <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  we_q       <= req_we;
                  addr_q     <= req_addr[WORDS_LOG2+1:0];
                  wdata_q    <= req_wdata;
                  resp_rdata <= '0;
                  resp_err   <= req_err;
               end
            end
            S_READ: begin
               rbuf <= mem_r_data;
               if (!we_q) resp_rdata <= ldata;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed plan plus random traffic against a transaction model.
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_w_en;
   logic [31:0] mem_w_data;
   logic [5:0]  mem_addr;
   logic [31:0] mem_r_data;

   bit [31:0] mem [64];
   bit [31:0] ref_mem [64];

   int total = 0;
   int bad = 0;

   // literal expectations for the handshake of the current directed transaction
   bit          lit_en = 1'b0;
   logic [31:0] lit_rd = 32'h0;
   logic        lit_err = 1'b0;
   int          lit_lat = 0;
   bit          fin_req = 1'b0;
   bit          fin_done = 1'b0;

   // model state
   bit          m_busy = 1'b0;
   int          m_cnt = 0;
   int          m_lat = 0;
   logic        m_err = 1'b0;
   logic [31:0] m_rd = 32'h0;
   bit          m_wr = 1'b0;
   logic [31:0] m_new = 32'h0;
   int          m_idx = 0;

   always #5 clk = ~clk;

   assign mem_r_data = mem[mem_addr];
   always @(posedge clk) if (mem_w_en) mem[mem_addr] <= mem_w_data;

   lsu_mem_ctrl #(.WORDS_LOG2(6), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_w_en(mem_w_en), .mem_w_data(mem_w_data), .mem_addr(mem_addr), .mem_r_data(mem_r_data)
   );

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Compare process: one transaction model stepped on every falling edge.
   initial begin : cmp
      logic [31:0] a, w, wd, b, h;
      int          op, lane, sh, hs;
      bit          we, illegal, mis, oor, wcyc;
      forever begin
         @(negedge clk);
         if (fin_req && !fin_done) begin
            for (int i = 0; i < 64; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
            fin_done = 1'b1;
         end else if (!reset) begin
            m_busy = 1'b0;
            m_idx  = 0;
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_mem_w_en",   32'(mem_w_en),   32'd0);
            chk("rst_mem_addr",   32'(mem_addr),   32'd0);
            chk("rst_resp_rdata", resp_rdata,      32'd0);
            chk("rst_resp_err",   32'(resp_err),   32'd0);
            chk("rst_req_ready",  32'(req_ready),  32'd1);
         end else begin
            chk("req_ready",  32'(req_ready),  32'(!m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(m_busy && m_cnt >= m_lat));
            chk("mem_addr",   32'(mem_addr),   32'(m_idx));
            if (m_busy && m_cnt >= m_lat) begin
               chk("resp_rdata", resp_rdata,    m_rd);
               chk("resp_err",   32'(resp_err), 32'(m_err));
               if (resp_ready && lit_en) begin
                  chk("lit_rdata",   resp_rdata,    lit_rd);
                  chk("lit_err",     32'(resp_err), 32'(lit_err));
                  chk("lit_latency", 32'(m_lat),    32'(lit_lat));
               end
            end
            wcyc = m_busy && m_wr && (m_cnt == m_lat - 1);
            chk("mem_w_en", 32'(mem_w_en), 32'(wcyc));
            if (wcyc) begin
               chk("mem_w_data", mem_w_data, m_new);
               ref_mem[m_idx] = m_new;
            end
            // predict what the coming rising edge does
            if (m_busy) begin
               if (m_cnt >= m_lat) begin
                  if (resp_ready) m_busy = 1'b0;
               end else begin
                  m_cnt++;
               end
            end else if (req_valid) begin
               a  = req_addr;
               op = int'(req_op);
               we = req_we;
               wd = req_wdata;
               illegal = (op == 3) || (op >= 6) || (we && op >= 4);
               mis     = ((op % 4 == 1) && (a % 2 != 0)) || ((op % 4 == 2) && (a % 4 != 0));
               oor     = a >= 32'd256;
               m_idx   = int'((a >> 2) % 64);
               lane    = int'(a % 4);
               sh      = 8 * lane;
               hs      = 8 * (lane & 2);
               w       = ref_mem[m_idx];
               m_busy  = 1'b1;
               m_cnt   = 1;
               m_err   = illegal || mis || oor;
               m_rd    = 32'h0;
               m_wr    = 1'b0;
               m_new   = 32'h0;
               if (m_err) begin
                  m_lat = 1;
               end else if (we) begin
                  m_wr  = 1'b1;
                  m_lat = (op == 2) ? 2 : 3;
                  if (op == 0)      m_new = (w & ~(32'hff << sh)) | ((wd & 32'hff) << sh);
                  else if (op == 1) m_new = (w & ~(32'hffff << hs)) | ((wd & 32'hffff) << hs);
                  else              m_new = wd;
               end else begin
                  m_lat = 2;
                  b = (w >> sh) & 32'hff;
                  h = (w >> hs) & 32'hffff;
                  case (op)
                     0: m_rd = (b >= 128) ? b + 32'hffff_ff00 : b;
                     1: m_rd = (h >= 32768) ? h + 32'hffff_0000 : h;
                     4: m_rd = b;
                     5: m_rd = h;
                     default: m_rd = w;
                  endcase
               end
            end
         end
      end
   end

   task automatic wait_accept(input bit drop);
      int n = 0;
      do begin @(negedge clk); n++; end while (!req_ready && n < 40);
      if (!req_ready) begin
         $display("FAIL accept_timeout got=0 want=1");
         $fatal(1, "no accept");
      end
      @(posedge clk); #1;
      if (drop) req_valid = 1'b0;
   endtask

   task automatic finish_resp(input int d);
      int n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
      if (!resp_valid) begin
         $display("FAIL resp_timeout got=0 want=1");
         $fatal(1, "no response");
      end
      repeat (d) @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
   endtask

   task automatic txn(input logic [2:0] op, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input int d, input bit use_lit, input logic [31:0] lrd, input logic lerr, input int llat);
      @(posedge clk); #1;
      req_op = op; req_we = we; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      lit_en = use_lit; lit_rd = lrd; lit_err = lerr; lit_lat = llat;
      wait_accept(1'b1);
      finish_resp(d);
      lit_en = 1'b0;
   endtask

   initial begin : stim
      int n;
      logic [31:0] a;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // directed plan with hand-computed results
      txn(3'b010, 1, 32'h10,  32'hDEADBEEF, 1, 1, 32'h0,        0, 2);
      txn(3'b010, 0, 32'h10,  32'h0,        1, 1, 32'hDEADBEEF, 0, 2);
      txn(3'b000, 1, 32'h11,  32'h55,       2, 1, 32'h0,        0, 3);
      txn(3'b010, 0, 32'h10,  32'h0,        1, 1, 32'hDEAD55EF, 0, 2);
      txn(3'b000, 0, 32'h11,  32'h0,        1, 1, 32'h00000055, 0, 2);
      txn(3'b000, 0, 32'h13,  32'h0,        1, 1, 32'hFFFFFFDE, 0, 2);
      txn(3'b100, 0, 32'h13,  32'h0,        1, 1, 32'h000000DE, 0, 2);
      txn(3'b001, 1, 32'h16,  32'h8001,     1, 1, 32'h0,        0, 3);
      txn(3'b001, 0, 32'h16,  32'h0,        1, 1, 32'hFFFF8001, 0, 2);
      txn(3'b101, 0, 32'h16,  32'h0,        1, 1, 32'h00008001, 0, 2);
      txn(3'b001, 0, 32'h15,  32'h0,        1, 1, 32'h0,        1, 1);
      txn(3'b001, 1, 32'h15,  32'h1234,     1, 1, 32'h0,        1, 1);
      txn(3'b010, 1, 32'hFC,  32'h12345678, 1, 1, 32'h0,        0, 2);
      txn(3'b010, 0, 32'hFC,  32'h0,        1, 1, 32'h12345678, 0, 2);
      txn(3'b010, 0, 32'h100, 32'h0,        1, 1, 32'h0,        1, 1);
      txn(3'b010, 1, 32'h102, 32'h1,        1, 1, 32'h0,        1, 1);
      txn(3'b011, 0, 32'h20,  32'h0,        1, 1, 32'h0,        1, 1);
      txn(3'b100, 1, 32'h20,  32'h1,        1, 1, 32'h0,        1, 1);

      // back-pressure: response held 5 cycles while a second request waits
      @(posedge clk); #1;
      req_op = 3'b010; req_we = 0; req_addr = 32'h10; req_valid = 1'b1;
      lit_en = 1; lit_rd = 32'hDEAD55EF; lit_err = 0; lit_lat = 2;
      wait_accept(1'b0);
      req_op = 3'b000; req_addr = 32'h13;
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
      repeat (5) @(negedge clk);
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk); #1 resp_ready = 1'b0;
      lit_en = 1; lit_rd = 32'hFFFFFFDE; lit_err = 0; lit_lat = 2;
      wait_accept(1'b1);
      finish_resp(1);
      lit_en = 0;

      // reset while the sub-word store is in its write cycle
      txn(3'b010, 1, 32'h20, 32'hCAFEF00D, 1, 1, 32'h0, 0, 2);
      @(posedge clk); #1;
      req_op = 3'b000; req_we = 1; req_addr = 32'h20; req_wdata = 32'h77; req_valid = 1'b1;
      wait_accept(1'b1);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      txn(3'b010, 0, 32'h20, 32'h0, 1, 1, 32'hCAFEF00D, 0, 2);

      // reset while a response is pending drops it
      @(posedge clk); #1;
      req_op = 3'b010; req_we = 0; req_addr = 32'h10; req_valid = 1'b1;
      wait_accept(1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!resp_valid && n < 40);
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // random traffic
      for (int i = 0; i < 250; i++) begin
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 263));
         if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
         txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(1, 3), 0, 32'h0, 0, 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      fin_req = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!fin_done && n < 10);
      if (!fin_done) begin
         $display("FAIL final_sweep_timeout got=0 want=1");
         $fatal(1, "sweep stuck");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
